// File: rtl/prbs_checker.sv
// Self-synchronising checker for a left-shifting two-tap LFSR bit stream: seeds, verifies, locks, counts errors.
// Outputs are registered and update on the edge that samples each valid bit; no backpressure (valid_i only qualifies).
module prbs_checker #(
    parameter int WIDTH       = 4,
    parameter int TAP_A       = 1,
    parameter int TAP_B       = 3,
    parameter int LOCK_THRESH = 8,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [LW-1:0]    miss_q, miss_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pred;

    assign pred = sr_q[TAP_A] ^ sr_q[TAP_B];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (valid_i) begin
            case (state_q)
                SEED: begin
                    sr_d = {sr_q[WIDTH-2:0], data_i};
                    if (fill_q == FW'(WIDTH - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[WIDTH-2:0], data_i};
                    // An all-zero register predicts zeros forever, so it never counts as a match.
                    if ((data_i == pred) && (sr_q != '0)) begin
                        if (match_q == MW'(LOCK_THRESH - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Shifting in the prediction keeps a flipped input bit from echoing into later predictions.
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (data_i != pred) begin
                        err_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (miss_q == LW'(LOSS_THRESH - 1)) begin
                            state_d = SEED;
                            sr_d    = '0;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + LW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end

        if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
            sr_q    <= '0;
            fill_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus queues expected outputs per cycle, a monitor compares on the falling edge.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        data_i;
    logic        clear_i;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_cnt_o;

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH(4), .TAP_A(1), .TAP_B(3), .LOCK_THRESH(8), .LOSS_THRESH(4), .CNT_W(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .clear_i  (clear_i),
        .locked_o (locked_o),
        .err_o    (err_o),
        .err_cnt_o(err_cnt_o)
    );

    typedef struct {
        logic        lk;
        logic        er;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         k      = 0;
    int         vc     = 0;
    // Generator stream from seed 4'b0001: 0,1,0,0,0,1 repeating (bit 0 first).
    logic [5:0] pat    = 6'b100010;

    task automatic send(input logic r, input logic v, input logic d, input logic c,
                        input logic lk, input logic er, input logic [15:0] cnt, input string nm);
        exp_t e;
        reset   = r;
        valid_i = v;
        data_i  = d;
        clear_i = c;
        @(posedge clk);
        e.lk   = lk;
        e.er   = er;
        e.cnt  = cnt;
        e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic sbit(input logic f, input logic c, input logic lk, input logic er,
                        input logic [15:0] cnt, input string nm);
        logic d;
        d = pat[k % 6] ^ f;
        k++;
        send(1'b0, 1'b1, d, c, lk, er, cnt, nm);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if (locked_o !== mon_e.lk || err_o !== mon_e.er || err_cnt_o !== mon_e.cnt) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got locked=%0b err=%0b cnt=%0d, expected locked=%0b err=%0b cnt=%0d",
                             mon_e.name, $time, locked_o, err_o, err_cnt_o, mon_e.lk, mon_e.er, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        data_i  = 1'b0;
        clear_i = 1'b0;

        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "reset");
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "reset");
        for (int i = 0; i < 5; i++)
            send(1'b0, 1'b0, 1'(($urandom & 1) != 0), 1'b0, 1'b0, 1'b0, 16'd0, "idle");

        // Acquisition: 4 fill bits + 8 matches, so lock shows after the 12th sampled bit.
        for (int i = 0; i < 100; i++)
            sbit(1'b0, 1'b0, 1'(i >= 11), 1'b0, 16'd0, "acquire");

        // Single flipped bit while locked.
        sbit(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, "flip1");
        for (int i = 0; i < 20; i++)
            sbit(1'b0, 1'b0, 1'b1, 1'b0, 16'd1, "post_flip1");

        // Clear, then four consecutive flips drop lock on the 4th.
        sbit(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, "clear");
        for (int j = 0; j < 4; j++)
            sbit(1'b1, 1'b0, 1'(j < 3), 1'b1, 16'(j + 1), "burst");
        for (int j = 0; j < 12; j++)
            sbit(1'b0, 1'b0, 1'(j >= 11), 1'b0, 16'd4, "relock");
        for (int j = 0; j < 5; j++)
            sbit(1'b0, 1'b0, 1'b1, 1'b0, 16'd4, "relocked");

        // Asynchronous reset mid-operation takes effect before any clock edge.
        reset = 1'b1;
        #1;
        n_cmp++;
        if (locked_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got locked=%0b err=%0b cnt=%0d, expected 0/0/0",
                     locked_o, err_o, err_cnt_o);
        end
        @(negedge clk);
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "reset_hold");

        // All-zero stream must never lock.
        for (int i = 0; i < 50; i++)
            send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "zeros");

        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "reset2");

        // 50% valid: lock point counted in valid bits only.
        vc = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 1) begin
                send(1'b0, 1'b0, 1'(($urandom & 1) != 0), 1'b0, 1'(vc >= 12), 1'b0, 16'd0, "gap");
            end else begin
                vc++;
                sbit(1'b0, 1'b0, 1'(vc >= 12), 1'b0, 16'd0, "half_rate");
            end
        end
        sbit(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, "half_flip");
        send(1'b0, 1'b0, 1'(($urandom & 1) != 0), 1'b0, 1'b1, 1'b0, 16'd1, "gap_err_low");
        sbit(1'b1, 1'b1, 1'b1, 1'b1, 16'd0, "clear_vs_err");
        sbit(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, "after_clear");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Serial receive-side checker for the team's LFSR pattern generator. The generator shifts left and inserts the feedback bit at the LSB. This block consumes that one-bit-per-cycle stream and self-synchronises to it by loading received bits into a local shift register. It then predicts each following bit, declares lock, counts bit errors and drops lock on sustained mismatch. It sits at the far end of a link or loopback path for BIST.

Parameters:
WIDTH, 4, LFSR length in bits; shift register width.
TAP_A, 1, first feedback tap index into the shift register (bit 0 = newest).
TAP_B, 3, second feedback tap index; predicted bit = sr[TAP_A] ^ sr[TAP_B].
LOCK_THRESH, 8, consecutive correct predictions required to declare lock (1..255).
LOSS_THRESH, 4, consecutive mismatches while locked that force loss of lock (1..255).
CNT_W, 16, error counter width.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
valid_i  input  1  data_i carries a stream bit this cycle.
data_i  input  1  received stream bit (generator's newly inserted LSB).
clear_i  input  1  synchronous clear of err_cnt_o; state machine unaffected.
locked_o  output  1  checker is locked to the stream.
err_o  output  1  one-cycle pulse, registered: previous sampled bit mismatched while LOCKED.
err_cnt_o  output  CNT_W  saturating count of locked-mode mismatches.

Behaviour:
- Reset (async, active-high): state=SEED; sr=0; fill, match and miss counters=0; locked_o=0; err_o=0; err_cnt_o=0.
- Nothing advances on cycles with valid_i=0. err_o is forced to 0 on those cycles. clear_i still acts.
- pred = sr[TAP_A]^sr[TAP_B], taken from sr before the shift.
- SEED:
  - On each valid bit: sr <= {sr[WIDTH-2:0], data_i}; fill++.
  - When fill reaches WIDTH, go to VERIFY; match=0.
- VERIFY:
  - On each valid bit: sr <= {sr[WIDTH-2:0], data_i}, so a corrupted bit flushes out.
  - If data_i==pred and sr before the shift is nonzero: match++. Otherwise match=0. The nonzero check prevents lock onto an all-zero stream.
  - When match reaches LOCK_THRESH, go to LOCKED. locked_o=1 from the edge that samples the LOCK_THRESH-th match.
- LOCKED:
  - On each valid bit: sr <= {sr[WIDTH-2:0], pred}. The prediction is shifted in, so a single flipped bit counts exactly one error.
  - On mismatch: err_o=1 for one cycle, err_cnt_o++ saturating at all-ones, miss++.
  - On match: miss=0.
  - When miss reaches LOSS_THRESH, go to SEED; locked_o=0; fill=0; sr=0. The errors that caused the loss are still counted.
- err_o and err_cnt_o update on the same edge that samples the offending bit.
- clear_i together with a counted error on the same edge: the clear wins and err_cnt_o=0. err_o still pulses.
- Counters are sized to their thresholds and never wrap.
- Reset mid-operation returns everything to reset values immediately.

Test Plan:
- Reset with valid_i=0 for 5 cycles -> locked_o=0, err_o=0, err_cnt_o=0, no state change.
- Drive the generator stream from seed 4'b0001 (bits 0,1,0,0,0,1 repeating), valid_i=1 every cycle -> locked_o rises on the 12th sampled bit (4 fill + 8 matches); err_cnt_o stays 0 over 100 bits.
- After lock, flip one bit -> exactly one err_o pulse and err_cnt_o=1; locked_o stays 1; the following bits produce no errors.
- After lock, flip 4 consecutive bits -> err_cnt_o=4, locked_o falls on the 4th error; a clean stream afterwards relocks within 12 valid bits.
- All-zero input for 50 bits -> locked_o never asserts.
- valid_i toggled 50% during lock -> identical lock point counted in valid bits; assert clear_i on the same edge as an error -> err_cnt_o=0 and err_o=1.
